// File: rtl/barrel_shift_r_seq_if.sv
// Handshake bundle for barrel_shift_r_seq: operand in, result out, plus busy status.
interface barrel_shift_r_seq_if #(
  parameter int ADDRESS_BITS = 3
);
  localparam int WIDTH = 2 ** ADDRESS_BITS;

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        num;
  logic [ADDRESS_BITS-1:0] amt;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        shifted;
  logic                    busy;

  modport master (
    output in_valid, num, amt, out_ready,
    input  in_ready, out_valid, shifted, busy
  );

  modport slave (
    input  in_valid, num, amt, out_ready,
    output in_ready, out_valid, shifted, busy
  );
endinterface

// File: rtl/barrel_shift_r_seq.sv
// Sequential right barrel shifter: one log stage (shift by 2^k) per clock.
// Optional ZERO_BYPASS_EN: amt==0 skips the shift stages and goes straight to DONE.
module barrel_shift_r_seq #(
  parameter int ADDRESS_BITS = 3,
  parameter bit ARITH        = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  barrel_shift_r_seq_if.slave bus
);
  localparam int WIDTH = 2 ** ADDRESS_BITS;
  localparam int STW   = $clog2(ADDRESS_BITS) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic [ADDRESS_BITS-1:0] amt_q, amt_d;
  logic                    fill_q, fill_d;
  logic [STW-1:0]          stage_q, stage_d;

  // Every stage's candidate result is built in parallel; the current stage picks one.
  logic [ADDRESS_BITS-1:0][WIDTH-1:0] stage_res;
  logic [WIDTH-1:0]                   cur_res;
  logic                               cur_bit;
  logic                               last_stage;

  for (genvar k = 0; k < ADDRESS_BITS; k++) begin : g_stage
    assign stage_res[k] = {{(2 ** k){fill_q}}, data_q[WIDTH-1:(2 ** k)]};
  end

  always_comb begin
    cur_res = data_q;
    cur_bit = 1'b0;
    for (int k = 0; k < ADDRESS_BITS; k++) begin
      if (stage_q == STW'(k)) begin
        cur_res = stage_res[k];
        cur_bit = amt_q[k];
      end
    end
  end

  assign last_stage = (stage_q == STW'(ADDRESS_BITS - 1));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    fill_d  = fill_q;
    stage_d = stage_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.num;
          amt_d   = bus.amt;
          fill_d  = ARITH ? bus.num[WIDTH-1] : 1'b0;
          stage_d = '0;
`ifdef ZERO_BYPASS_EN
          state_d = (bus.amt == '0) ? DONE : SHIFT;
`else
          state_d = SHIFT;
`endif
        end
      end
      SHIFT: begin
        if (cur_bit) data_d = cur_res;
        if (last_stage) begin
          stage_d = '0;
          state_d = DONE;
        end else begin
          stage_d = stage_q + STW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      fill_q  <= 1'b0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      fill_q  <= fill_d;
      stage_q <= stage_d;
    end
  end

  // Pure state decodes: nothing combinational from in_valid/out_ready reaches the outputs.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.shifted   = data_q;
endmodule

// File: tb/tb_barrel_shift_r_seq.sv
// Directed bench for barrel_shift_r_seq: logical and arithmetic instances, scoreboard queues.
module tb_barrel_shift_r_seq;
  localparam int AB  = 3;
  localparam int W   = 2 ** AB;
  localparam int LAT = AB + 1;
`ifdef ZERO_BYPASS_EN
  localparam int LAT0 = 1;
`else
  localparam int LAT0 = AB + 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  barrel_shift_r_seq_if #(.ADDRESS_BITS(AB)) if0 ();
  barrel_shift_r_seq_if #(.ADDRESS_BITS(AB)) if1 ();

  barrel_shift_r_seq #(.ADDRESS_BITS(AB), .ARITH(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  barrel_shift_r_seq #(.ADDRESS_BITS(AB), .ARITH(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] n, input logic [AB-1:0] a, input bit arith);
    logic signed [W-1:0] s;
    s = n;
    return arith ? W'(s >>> a) : (n >> a);
  endfunction

  // Scoreboard: pop and compare whenever a result handshake is about to happen.
  always @(negedge clk) begin
    if (rst_n && if0.out_valid && if0.out_ready) begin
      if (q0.size() == 0) chk("sb0_unexpected", 1, 0);
      else chk("sb0_data", 32'(if0.shifted), 32'(q0.pop_front()));
    end
    if (rst_n && if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) chk("sb1_unexpected", 1, 0);
      else chk("sb1_data", 32'(if1.shifted), 32'(q1.pop_front()));
    end
  end

  function automatic logic get_ov(input bit sel);
    return sel ? if1.out_valid : if0.out_valid;
  endfunction
  function automatic logic get_ir(input bit sel);
    return sel ? if1.in_ready : if0.in_ready;
  endfunction

  task automatic set_in(input bit sel, input logic v, input logic [W-1:0] n, input logic [AB-1:0] a);
    if (sel) begin if1.in_valid = v; if1.num = n; if1.amt = a; end
    else     begin if0.in_valid = v; if0.num = n; if0.amt = a; end
  endtask

  // Offer one operand, push its expected result, then count edges to out_valid.
  task automatic do_op(input bit sel, input logic [W-1:0] n, input logic [AB-1:0] a, input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk);
    chk("accept_in_ready", 32'(get_ir(sel)), 1);
    set_in(sel, 1'b1, n, a);
    @(posedge clk);
    if (sel) q1.push_back(ref_shift(n, a, 1'b1));
    else     q0.push_back(ref_shift(n, a, 1'b0));
    #1 set_in(sel, 1'b0, '0, '0);
    lat = 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (get_ov(sel)) seen = 1'b1;
      else begin
        chk("in_ready_low_while_busy", 32'(get_ir(sel)), 0);
        @(posedge clk);
        lat++;
      end
    end
    chk("out_valid_seen", 32'(seen), 1);
    chk("latency", 32'(lat), 32'(exp_lat));
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_handshake", 32'(get_ir(sel)), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, '0, '0);
    set_in(1'b1, 1'b0, '0, '0);
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    #23;
    chk("rst_in_ready", 32'(if0.in_ready), 1);
    chk("rst_out_valid", 32'(if0.out_valid), 0);
    chk("rst_busy", 32'(if0.busy), 0);
    chk("rst_shifted", 32'(if0.shifted), 0);
    chk("rst_arith_shifted", 32'(if1.shifted), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b0, 8'hA5, 3'd3, LAT);
    do_op(1'b1, 8'h80, 3'd7, LAT);
    do_op(1'b1, 8'h7F, 3'd7, LAT);
    do_op(1'b0, 8'h80, 3'd7, LAT);
    do_op(1'b1, 8'hA5, 3'd2, LAT);
    for (int a = 0; a < W; a++)
      do_op(1'b0, 8'hA5, AB'(a), (a == 0) ? LAT0 : LAT);

    // Backpressure: DONE must hold while out_ready is low and ignore new operands.
    if0.out_ready = 1'b0;
    @(negedge clk);
    set_in(1'b0, 1'b1, 8'hC3, 3'd1);
    @(posedge clk);
    q0.push_back(8'h61);
    #1 set_in(1'b0, 1'b1, 8'hFF, 3'd0);
    for (int i = 0; i < 20 && !if0.out_valid; i++) @(negedge clk);
    chk("bp_reached_done", 32'(if0.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(if0.out_valid), 1);
      chk("bp_shifted", 32'(if0.shifted), 32'h61);
      chk("bp_in_ready", 32'(if0.in_ready), 0);
    end
    @(posedge clk);
    #1;
    if0.out_ready = 1'b1;
    set_in(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_idle", 32'(if0.in_ready), 1);
    chk("bp_release_no_valid", 32'(if0.out_valid), 0);

    // Asynchronous reset during SHIFT stage 1 discards the operation.
    @(negedge clk);
    set_in(1'b0, 1'b1, 8'h3C, 3'd5);
    @(posedge clk);
    #1 set_in(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(if0.in_ready), 1);
    chk("arst_out_valid", 32'(if0.out_valid), 0);
    chk("arst_busy", 32'(if0.busy), 0);
    chk("arst_shifted", 32'(if0.shifted), 0);
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 8'hF0, 3'd4, LAT);

    repeat (3) @(negedge clk);
    chk("sb0_drained", 32'(q0.size()), 0);
    chk("sb1_drained", 32'(q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
